// File: rtl/i2s_feed_unit.sv
// i2s_feed_unit: stereo elastic FIFO feeding the I2S transmitter, with priming, under/overflow and standby flush.
// Optional I2S_FEED_REPEAT_EN: an underflow in RUN repeats the last popped pair instead of zeros.
module i2s_feed_unit #(
  parameter int DEPTH   = 8,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               play_in,
  input  logic               wr_tick_in,
  input  logic [23:0]        wr_audio0_in,
  input  logic [23:0]        wr_audio1_in,
  input  logic               req_in,
  output logic               tick_out,
  output logic [23:0]        audio0_out,
  output logic [23:0]        audio1_out,
  output logic [LEVEL_W-1:0] level_out,
  output logic               underflow_out,
  output logic               overflow_out
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {STANDBY, PRIME, RUN} state_t;
  state_t             state;
  logic [47:0]        mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               tick_q, active, serve, pop, push, full, empty;
  logic [LEVEL_W-1:0] level_nxt;
  logic [47:0]        head, fill;
  assign active    = play_in && state != STANDBY;
  assign full      = level_out == LEVEL_W'(DEPTH);
  assign empty     = level_out == '0;
  assign serve     = active && req_in;
  assign pop       = serve && state == RUN && !empty;
  assign push      = active && wr_tick_in && (!full || pop);
  assign level_nxt = level_out + LEVEL_W'(push) - LEVEL_W'(pop);
  assign head      = mem[rd_ptr];
  // A tick already registered is masked the moment play drops
  assign tick_out  = tick_q & play_in;
`ifdef I2S_FEED_REPEAT_EN
  logic [47:0] last;
  assign fill = last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= '0;
    else if (!play_in || state == STANDBY) last <= '0;
    else if (pop) last <= head;
`else
  assign fill = '0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {wr_audio0_in, wr_audio1_in};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STANDBY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_out     <= '0;
      tick_q        <= 1'b0;
      audio0_out    <= '0;
      audio1_out    <= '0;
      underflow_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else if (!play_in) begin
      state         <= STANDBY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_out     <= '0;
      tick_q        <= 1'b0;
      audio0_out    <= '0;
      audio1_out    <= '0;
      underflow_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else if (state == STANDBY) begin
      state <= PRIME;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      level_out <= level_nxt;
      tick_q    <= req_in;
      // PRIME answers with silence; RUN serves the head or the underflow fill
      if (req_in) {audio0_out, audio1_out} <= pop ? head : (state == RUN ? fill : 48'd0);
      if (serve && state == RUN && empty) underflow_out <= 1'b1;
      if (wr_tick_in && full && !pop) overflow_out <= 1'b1;
      if (state == PRIME && level_nxt >= LEVEL_W'(DEPTH / 2)) state <= RUN;
    end
  end
endmodule

// File: tb/tb_i2s_feed_unit.sv
// tb_i2s_feed_unit: directed + random stimulus against a queue-based reference model of the feed unit.
module tb_i2s_feed_unit;
  localparam int DEPTH = 8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        play_in = 1'b0, wr_tick_in = 1'b0, req_in = 1'b0;
  logic [23:0] wr_audio0_in = '0, wr_audio1_in = '0;
  logic        tick_out, underflow_out, overflow_out;
  logic [23:0] audio0_out, audio1_out;
  logic [3:0]  level_out;
  int errs = 0, checks = 0;
  logic [47:0] q[$];
  int          mode = 0;
  logic        m_tick = 0, m_uf = 0, m_of = 0;
  logic [47:0] m_a = '0, m_last = '0;

  i2s_feed_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .play_in(play_in), .wr_tick_in(wr_tick_in),
    .wr_audio0_in(wr_audio0_in), .wr_audio1_in(wr_audio1_in), .req_in(req_in),
    .tick_out(tick_out), .audio0_out(audio0_out), .audio1_out(audio1_out),
    .level_out(level_out), .underflow_out(underflow_out), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"}, 32'(tick_out), 32'(m_tick & play_in));
    chk({tag, ".a0"}, 32'(audio0_out), 32'(m_a[47:24]));
    chk({tag, ".a1"}, 32'(audio1_out), 32'(m_a[23:0]));
    chk({tag, ".level"}, 32'(level_out), 32'(q.size()));
    chk({tag, ".uf"}, 32'(underflow_out), 32'(m_uf));
    chk({tag, ".of"}, 32'(overflow_out), 32'(m_of));
  endtask

  task automatic model_clear();
    mode = 0; q.delete(); m_uf = 0; m_of = 0; m_a = '0; m_tick = 0; m_last = '0;
  endtask

  // Modes: 0 standby, 1 priming, 2 running
  task automatic model_step();
    int sz;
    bit popped;
    if (!play_in) model_clear();
    else if (mode == 0) begin
      mode = 1;
      m_tick = 0;
    end else begin
      sz = q.size();
      popped = mode == 2 && req_in && sz > 0;
      m_tick = req_in;
      if (req_in) begin
        if (popped) begin
          m_a = q.pop_front();
          m_last = m_a;
        end else if (mode == 2) begin
          m_uf = 1;
`ifdef I2S_FEED_REPEAT_EN
          m_a = m_last;
`else
          m_a = '0;
`endif
        end else m_a = '0;
      end
      if (wr_tick_in) begin
        if (sz < DEPTH || popped) q.push_back({wr_audio0_in, wr_audio1_in});
        else m_of = 1;
      end
      if (mode == 1 && q.size() >= DEPTH / 2) mode = 2;
    end
  endtask

  task automatic step(input string tag, input logic p, input logic w, input logic r,
                      input logic [23:0] a0, input logic [23:0] a1);
    play_in = p; wr_tick_in = w; req_in = r; wr_audio0_in = a0; wr_audio1_in = a1;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rstep(input string tag, input logic w, input logic r);
    step(tag, 1'b1, w, r, 24'($urandom), 24'($urandom));
  endtask

  initial begin
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, '0, '0);
    step("start", 1'b1, 1'b0, 1'b0, '0, '0);
    step("p_w1", 1'b1, 1'b1, 1'b0, 24'h000001, 24'h100001);
    step("p_r1", 1'b1, 1'b0, 1'b1, '0, '0);
    step("p_w2", 1'b1, 1'b1, 1'b0, 24'h000002, 24'h100002);
    step("p_r2", 1'b1, 1'b0, 1'b1, '0, '0);
    step("p_w3", 1'b1, 1'b1, 1'b0, 24'h000003, 24'h100003);
    step("p_r3", 1'b1, 1'b0, 1'b1, '0, '0);
    step("p_w4", 1'b1, 1'b1, 1'b0, 24'h000004, 24'h100004);
    step("run_r", 1'b1, 1'b0, 1'b1, '0, '0);
    chk("prime_first_a0", 32'(audio0_out), 32'h000001);
    chk("prime_first_a1", 32'(audio1_out), 32'h100001);
    chk("prime_first_tick", 32'(tick_out), 32'd1);
    for (int i = 0; i < 9; i++) rstep("ovf_w", 1'b1, 1'b0);
    chk("ovf_level", 32'(level_out), 32'd8);
    chk("ovf_flag", 32'(overflow_out), 32'd1);
    rstep("full_wr", 1'b1, 1'b1);
    chk("full_wr_level", 32'(level_out), 32'd8);
    for (int i = 0; i < 8; i++) rstep("drain", 1'b0, 1'b1);
    rstep("udf", 1'b0, 1'b1);
    chk("udf_flag", 32'(underflow_out), 32'd1);
    rstep("empty_wr", 1'b1, 1'b1);
    chk("empty_wr_level", 32'(level_out), 32'd1);
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 49) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
           24'($urandom), 24'($urandom));
    step("re_play", 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) rstep("refill", 1'b1, 1'b0);
    rstep("st_req", 1'b0, 1'b1);
    play_in = 1'b0;
    #1;
    chk("st_tick_masked", 32'(tick_out), 32'd0);
    step("st_clear", 1'b0, 1'b0, 1'b0, '0, '0);
    step("st_wr", 1'b0, 1'b1, 1'b0, 24'h123456, 24'h654321);
    step("st_wr2", 1'b0, 1'b1, 1'b1, 24'h0abcde, 24'h0edcba);
    step("play2", 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) rstep("r_fill", 1'b1, 1'b0);
    rstep("r_pop", 1'b0, 1'b1);
    chk("pre_rst_level", 32'(level_out), 32'd5);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b0, 1'b0, '0, '0);
    rstep("post_w", 1'b1, 1'b0);
    rstep("post_r", 1'b0, 1'b1);
    chk("post_prime_a0", 32'(audio0_out), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/i2s_feed_unit.md
Name: i2s_feed_unit

Overview:
- Stereo sample elastic buffer directly upstream of the I2S transmitter.
- Accepts 24-bit left/right sample pairs from the DSP path on a single-cycle write strobe and stores them in a FIFO.
- On each I2S data request pulse, pops one pair and presents it with a one-cycle tick, matching the transmitter's tick/audio latch interface.
- Handles start-up priming, underflow, overflow and standby flushing.

Parameters:
- DEPTH, 8, FIFO depth in stereo pairs; power of two, minimum 4.
- LEVEL_W, $clog2(DEPTH)+1, width of the level output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- play_in  in  1  play mode; low = standby
- wr_tick_in  in  1  single-cycle write strobe from DSP path
- wr_audio0_in  in  24  left sample, valid with wr_tick_in
- wr_audio1_in  in  24  right sample, valid with wr_tick_in
- req_in  in  1  single-cycle data request from I2S transmitter
- tick_out  out  1  single-cycle pulse; audio outputs updated this cycle
- audio0_out  out  24  left sample to I2S transmitter
- audio1_out  out  24  right sample to I2S transmitter
- level_out  out  LEVEL_W  current FIFO occupancy, 0..DEPTH
- underflow_out  out  1  sticky: request served while FIFO empty in RUN
- overflow_out  out  1  sticky: write dropped because FIFO full

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FIFO pointers 0, state STANDBY.
- States and transitions:
  - STANDBY -> PRIME when play_in = 1.
  - PRIME -> RUN when level reaches DEPTH/2.
  - Any state -> STANDBY when play_in = 0 (checked first; overrides everything).
- STANDBY:
  - FIFO flushed (pointers and level 0), writes ignored.
  - tick_out = 0; audio0_out/audio1_out = 0.
  - underflow_out and overflow_out cleared.
- Writes (PRIME/RUN): wr_tick_in with level < DEPTH stores the pair; level +1 on the next cycle.
- Overflow: wr_tick_in with level = DEPTH, no simultaneous pop -> pair dropped, overflow_out set.
- Simultaneous push and pop when full: write accepted, level unchanged, no overflow.
- Request latency: req_in in cycle N -> tick_out = 1 in cycle N+1. audio0_out/audio1_out take the new value in cycle N+1 and hold until the next tick.
- PRIME response: req_in answered with tick_out carrying zeros; FIFO not popped; not an underflow.
- RUN response with level > 0: head pair popped; level -1 (net 0 if a write occurs in the same cycle).
- RUN underflow: level = 0 at req_in (registered level, no write bypass) -> zeros output, tick_out still pulsed, underflow_out set. A same-cycle write is stored normally.
- tick_out is never high while play_in = 0. If play_in falls between req_in and the response cycle, the tick is suppressed.
- Pointers wrap modulo DEPTH; level is held separately so full and empty are unambiguous.
- req_in asserted for multiple cycles: each high cycle counts as a request. Upstream guarantees pulses.
- Reset mid-operation: immediate return to reset values; FIFO contents discarded.

Optional Feature:
- Macro: I2S_FEED_REPEAT_EN.
- Defined: an RUN underflow re-presents the last popped pair instead of zeros. tick_out is still pulsed and underflow_out still set. The last-pair register is cleared in STANDBY, so the first underflow before any pop yields zeros.
- Undefined: underflow outputs zeros as specified above. No last-pair register is implemented.

Test Plan:
- Priming: reset, play_in = 1, DEPTH = 8, write pairs 0x000001/0x100001 .. 0x000004/0x100004 with req_in pulses interleaved -> ticks carry zeros until level = 4. The next req yields audio0_out = 0x000001, audio1_out = 0x100001 one cycle after req_in.
- Overflow: in RUN, write 9 pairs with no requests -> level_out = 8, overflow_out = 1, 9th pair absent from the read-back sequence.
- Underflow: in RUN, drain to level 0, issue req_in -> tick_out pulse, outputs 0 (last popped pair with I2S_FEED_REPEAT_EN), underflow_out = 1.
- Simultaneous events:
  - Full FIFO plus wr_tick_in and req_in in the same cycle -> level stays 8, no overflow, new pair queued last.
  - Empty in RUN plus both -> underflow_out = 1, level becomes 1.
- Standby: play_in falls one cycle after req_in -> no tick_out. All outputs, level_out and both flags read 0 the next cycle. Writes during standby are ignored.
- Async reset asserted mid-RUN with level = 5 -> outputs 0 immediately, level_out = 0 after release, state STANDBY.
